camera_controller: RTL and testbench



---
 rtl/camera_controller_pkg.sv | 33 +++
 rtl/camera_controller_if.sv | 23 ++
 rtl/camera_controller_level_divider.sv | 57 +++++
 rtl/camera_controller.sv | 123 ++++++++++++
 tb/tb_camera_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/camera_controller_pkg.sv
// Shared constants and state encoding for the camera controller and the map renderer.
package camera_controller_pkg;

    localparam int PHY_WIDTH    = 16;
    localparam int CAMERA_WIDTH = 6;

    localparam logic [PHY_WIDTH-1:0]    SCREEN_HEIGHT = 16'd470;
    localparam logic [PHY_WIDTH-1:0]    WALL_WIDTH    = 16'd16;
    localparam logic [CAMERA_WIDTH-1:0] MAX_LEVEL     = {CAMERA_WIDTH{1'b1}};
    localparam logic [CAMERA_WIDTH-1:0] SCROLL_STEP   = 6'd8;
    localparam logic [CAMERA_WIDTH-1:0] OFFSET_START  = {CAMERA_WIDTH{1'b1}};
    localparam logic [CAMERA_WIDTH-1:0] CAM_ZERO      = {CAMERA_WIDTH{1'b0}};
    localparam logic [CAMERA_WIDTH-1:0] CAM_ONE       = {{(CAMERA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SCROLL = 2'd3
    } cam_state_e;

    // One frame of scroll animation; clamps at zero instead of wrapping.
    function automatic logic [CAMERA_WIDTH-1:0] scroll_down(input logic [CAMERA_WIDTH-1:0] off);
        logic [CAMERA_WIDTH-1:0] res;
        if (off > SCROLL_STEP) begin
            res = off - SCROLL_STEP;
        end else begin
            res = CAM_ZERO;
        end
        return res;
    endfunction

endpackage

// File: rtl/camera_controller_if.sv
// Player-position input and camera output bundle between the game logic and the camera controller.
interface camera_controller_if;
    import camera_controller_pkg::*;

    logic                    frame_tick;
    logic                    player_valid;
    logic [PHY_WIDTH-1:0]    player_y;
    logic [CAMERA_WIDTH-1:0] camera_y;
    logic [CAMERA_WIDTH-1:0] camera_offset;
    logic                    level_changed;
    logic                    busy;

    modport master (
        output frame_tick, player_valid, player_y,
        input  camera_y, camera_offset, level_changed, busy
    );

    modport slave (
        input  frame_tick, player_valid, player_y,
        output camera_y, camera_offset, level_changed, busy
    );

endinterface

// File: rtl/camera_controller_level_divider.sv
// Repeated-subtraction divide by SCREEN_HEIGHT with quotient saturating at MAX_LEVEL.
module camera_controller_level_divider
    import camera_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PHY_WIDTH-1:0]    dividend,
    output logic                    done,
    output logic [CAMERA_WIDTH-1:0] quotient
);

    logic [PHY_WIDTH-1:0]    rem_d, rem_q;
    logic [CAMERA_WIDTH-1:0] cnt_d, cnt_q;
    logic                    run_d, run_q;
    logic                    sub_ok_s;

    assign sub_ok_s = (rem_q >= SCREEN_HEIGHT) && (cnt_q < MAX_LEVEL);
    // done is the last running cycle; cnt_q is held afterwards for the commit.
    assign done     = run_q && !sub_ok_s;
    assign quotient = cnt_q;

    // Load on start, then subtract one screen per cycle until done.
    always_comb begin
        rem_d = rem_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = dividend;
            cnt_d = CAM_ZERO;
            run_d = 1'b1;
        end else if (run_q) begin
            if (sub_ok_s) begin
                rem_d = rem_q - SCREEN_HEIGHT;
                cnt_d = cnt_q + CAM_ONE;
            end else begin
                run_d = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= {PHY_WIDTH{1'b0}};
            cnt_q <= CAM_ZERO;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/camera_controller.sv
// Camera controller: player world Y -> level index plus scroll-offset animation.
// Optional build macro CAMERA_SCROLL_ANIM_EN enables the SCROLL state and offset animation.
module camera_controller
    import camera_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    camera_controller_if.slave cam
);

    cam_state_e              state_d, state_q;
    logic [CAMERA_WIDTH-1:0] camera_y_d, camera_y_q;
    logic                    level_changed_d, level_changed_q;
    logic                    busy_d, busy_q;
    logic                    start_s;
    logic                    div_done_s;
    logic [CAMERA_WIDTH-1:0] quotient_s;
`ifdef CAMERA_SCROLL_ANIM_EN
    logic [CAMERA_WIDTH-1:0] camera_offset_d, camera_offset_q;
`endif

    camera_controller_level_divider u_level_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .dividend (cam.player_y),
        .done     (div_done_s),
        .quotient (quotient_s)
    );

    // Next state, level commit and per-frame scroll animation.
    always_comb begin
        state_d         = state_q;
        camera_y_d      = camera_y_q;
        level_changed_d = 1'b0;
        start_s         = 1'b0;
`ifdef CAMERA_SCROLL_ANIM_EN
        camera_offset_d = camera_offset_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cam.frame_tick && cam.player_valid) begin
                    start_s = 1'b1;
                    state_d = ST_DIVIDE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (div_done_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_COMMIT: begin
                if (quotient_s == camera_y_q) begin
                    state_d = ST_IDLE;
                end else begin
                    camera_y_d      = quotient_s;
                    level_changed_d = 1'b1;
`ifdef CAMERA_SCROLL_ANIM_EN
                    camera_offset_d = OFFSET_START;
                    state_d         = ST_SCROLL;
`else
                    state_d         = ST_IDLE;
`endif
                end
            end
`ifdef CAMERA_SCROLL_ANIM_EN
            ST_SCROLL: begin
                // Ticks here only animate; they never launch a new divide.
                if (camera_offset_q == CAM_ZERO) begin
                    state_d = ST_IDLE;
                end else if (cam.frame_tick) begin
                    camera_offset_d = scroll_down(camera_offset_q);
                end else begin
                    state_d = ST_SCROLL;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            camera_y_q      <= CAM_ZERO;
            level_changed_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            camera_y_q      <= camera_y_d;
            level_changed_q <= level_changed_d;
            busy_q          <= busy_d;
        end
    end

`ifdef CAMERA_SCROLL_ANIM_EN
    // Scroll offset register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            camera_offset_q <= CAM_ZERO;
        end else begin
            camera_offset_q <= camera_offset_d;
        end
    end

    assign cam.camera_offset = camera_offset_q;
`else
    assign cam.camera_offset = CAM_ZERO;
`endif

    assign cam.camera_y      = camera_y_q;
    assign cam.level_changed = level_changed_q;
    assign cam.busy          = busy_q;

endmodule

// File: tb/tb_camera_controller.sv
// Randomized self-checking bench for camera_controller against a frame-level reference model.
module tb_camera_controller;

`ifdef CAMERA_SCROLL_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   model_level;

    camera_controller_if cam_if ();

    camera_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cam   (cam_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit t, input bit v, input int y);
        cam_if.frame_tick   = t;
        cam_if.player_valid = v;
        cam_if.player_y     = y[15:0];
    endtask

    // Reference level: whole screens of 470 pixels, saturating at 63.
    function automatic int level_of(input int y);
        int q;
        q = y / 470;
        if (q > 63) q = 63;
        return q;
    endfunction

    // One accepted frame tick: q+1 divide cycles, commit on edge q+2.
    task automatic do_frame(input int y, input bit noise);
        int q;
        int old;
        bit chg;
        q   = level_of(y);
        old = model_level;
        chg = (q != old);
        drive(1'b1, 1'b1, y);
        step();
        check("busy_start", cam_if.busy, 1);
        for (int k = 1; k <= q + 1; k++) begin
            if (noise) drive(1'b1, 1'b1, 1500);
            else       drive(1'b0, 1'b0, 0);
            step();
            check("busy_divide", cam_if.busy, 1);
            check("cam_y_hold", cam_if.camera_y, old);
            check("lc_quiet", cam_if.level_changed, 0);
        end
        if (noise) drive(1'b1, 1'b1, 1500);
        else       drive(1'b0, 1'b0, 0);
        step();
        drive(1'b0, 1'b0, 0);
        check("cam_y_commit", cam_if.camera_y, q);
        check("lc_pulse", cam_if.level_changed, chg);
        check("offset_commit", cam_if.camera_offset, (ANIM && chg) ? 63 : 0);
        check("busy_commit", cam_if.busy, ANIM && chg);
        model_level = q;
        step();
        check("lc_clear", cam_if.level_changed, 0);
        check("busy_after", cam_if.busy, ANIM && chg);
    endtask

`ifdef CAMERA_SCROLL_ANIM_EN
    task automatic scroll_out(input int nticks);
        int exp;
        exp = 63;
        for (int i = 0; i < nticks && exp != 0; i++) begin
            repeat ($urandom_range(0, 2)) begin
                drive(1'b0, 1'b0, 0);
                step();
                check("offset_hold", cam_if.camera_offset, exp);
                check("busy_scroll", cam_if.busy, 1);
            end
            drive(1'b1, 1'b1, $urandom_range(0, 65535));
            step();
            exp = (exp > 8) ? exp - 8 : 0;
            check("offset_step", cam_if.camera_offset, exp);
            check("cam_y_scroll", cam_if.camera_y, model_level);
            check("busy_scroll", cam_if.busy, 1);
        end
        drive(1'b0, 1'b0, 0);
        if (exp == 0) begin
            step();
            check("busy_scroll_end", cam_if.busy, 0);
            check("offset_end", cam_if.camera_offset, 0);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        failures    = 0;
        model_level = 0;
        rst_n       = 1'b0;
        drive(1'b0, 1'b0, 0);
        step();
        step();
        check("rst_cam_y", cam_if.camera_y, 0);
        check("rst_offset", cam_if.camera_offset, 0);
        check("rst_busy", cam_if.busy, 0);
        check("rst_lc", cam_if.level_changed, 0);
        rst_n = 1'b1;
        step();

        do_frame(100, 1'b0);
        do_frame(1000, 1'b0);
`ifdef CAMERA_SCROLL_ANIM_EN
        scroll_out(8);
`endif
        do_frame(65535, 1'b1);
`ifdef CAMERA_SCROLL_ANIM_EN
        scroll_out(8);
        do_frame(1000, 1'b0);
        scroll_out(4);
        check("offset_pre_rst", cam_if.camera_offset, 31);
`else
        drive(1'b1, 1'b1, 65535);
        step();
        drive(1'b0, 1'b0, 0);
        repeat (10) step();
        check("busy_pre_rst", cam_if.busy, 1);
`endif
        // Asynchronous reset asserted between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cam_y", cam_if.camera_y, 0);
        check("arst_offset", cam_if.camera_offset, 0);
        check("arst_busy", cam_if.busy, 0);
        check("arst_lc", cam_if.level_changed, 0);
        model_level = 0;
        step();
        step();
        rst_n = 1'b1;
        step();

        do_frame(0, 1'b0);
        do_frame(1500, 1'b1);
`ifdef CAMERA_SCROLL_ANIM_EN
        scroll_out(8);
`endif
        drive(1'b1, 1'b0, 3000);
        step();
        drive(1'b0, 1'b0, 0);
        check("tick_no_valid", cam_if.busy, 0);

        for (int n = 0; n < 40; n++) begin
            int  y;
            int  old;
            bit  nz;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 65535);
            else                           y = $urandom_range(0, 4000);
            nz = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) == 0) begin
                drive(1'b1, 1'b0, y);
                step();
                drive(1'b0, 1'b0, 0);
                check("rand_no_valid", cam_if.busy, 0);
            end
            old = model_level;
            do_frame(y, nz);
`ifdef CAMERA_SCROLL_ANIM_EN
            if (model_level != old) scroll_out(8);
`else
            check("rand_offset_zero", cam_if.camera_offset, 0);
`endif
            repeat ($urandom_range(0, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
